// File: rtl/lfsr_seed_load_pkg.sv
// Shared definitions for the LFSR seed load / readback controllers:
// chain length, word mapping helpers and the common FSM state encoding.
package lfsr_seed_load_pkg;

    localparam int WORD_BITS       = 32;
    localparam int SHIFT_CYCLE_DEF = 320;
    localparam int WORDS_PER_CHAIN = SHIFT_CYCLE_DEF / WORD_BITS;

    // Words 0..WORDS_PER_CHAIN-1 go to chain 0, the rest to chain 1.
    localparam int CHAIN0_FIRST_WORD = 0;
    localparam int CHAIN1_FIRST_WORD = WORDS_PER_CHAIN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REQ,
        ST_LOAD_CAP,
        ST_MODE_ON,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_MODE_OFF,
        ST_DONE
    } lfsr_state_e;

    function automatic int words_per_chain(input int shift_cycle);
        return shift_cycle / WORD_BITS;
    endfunction

endpackage

// File: rtl/lfsr_seed_load_if.sv
// Pipe-in FIFO read port bundle.
// master: the consumer (drives rd_en); slave: the FIFO (drives empty, dout).
interface lfsr_seed_load_if;

    logic        in_fifo_empty;
    logic        in_fifo_rd_en;
    logic [31:0] in_fifo_dout;

    modport master (
        output in_fifo_rd_en,
        input  in_fifo_empty,
        input  in_fifo_dout
    );

    modport slave (
        input  in_fifo_rd_en,
        output in_fifo_empty,
        output in_fifo_dout
    );

endinterface

// File: rtl/lfsr_seed_load_buffer.sv
// Two SHIFT_CYCLE-bit seed registers with a word write port and a
// parallel shift-right. Ports: wr_en/wr_idx/wr_data, shift_en, lsb[1:0].
module lfsr_seed_load_buffer
    import lfsr_seed_load_pkg::*;
#(
    parameter int SHIFT_CYCLE = SHIFT_CYCLE_DEF,
    parameter int IDX_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic             shift_en,
    output logic [1:0]       lsb
);

    localparam int WPC = words_per_chain(SHIFT_CYCLE);

    logic [SHIFT_CYCLE-1:0] chain0_q, chain0_d;
    logic [SHIFT_CYCLE-1:0] chain1_q, chain1_d;

    always_comb begin
        chain0_d = chain0_q;
        chain1_d = chain1_q;
        if (wr_en) begin
            for (int k = 0; k < WPC; k++) begin
                if (wr_idx == IDX_W'(CHAIN0_FIRST_WORD + k))
                    chain0_d[k*WORD_BITS +: WORD_BITS] = wr_data;
                if (wr_idx == IDX_W'(WPC + k))
                    chain1_d[k*WORD_BITS +: WORD_BITS] = wr_data;
            end
        end else if (shift_en) begin
            chain0_d = {1'b0, chain0_q[SHIFT_CYCLE-1:1]};
            chain1_d = {1'b0, chain1_q[SHIFT_CYCLE-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain0_q <= '0;
            chain1_q <= '0;
        end else begin
            chain0_q <= chain0_d;
            chain1_q <= chain1_d;
        end
    end

    assign lsb = {chain1_q[0], chain0_q[0]};

endmodule

// File: rtl/lfsr_seed_load.sv
// Loads a host seed from the pipe-in FIFO into both LFSR scan chains.
// Ports: trigger/abort, FIFO read port (if), lfsr_clk/dout/load_mode, busy/done.
module lfsr_seed_load
    import lfsr_seed_load_pkg::*;
#(
    parameter int SHIFT_CYCLE = SHIFT_CYCLE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lfsr_load_trigger,
    input  logic                     lfsr_load_abort,
    lfsr_seed_load_if.master         fifo,
    output logic                     lfsr_clk,
    output logic [1:0]               lfsr_dout,
    output logic                     lfsr_load_mode,
    output logic                     load_busy,
    output logic                     load_done
);

    localparam int WORDS = 2 * words_per_chain(SHIFT_CYCLE);
    localparam int WCW   = $clog2(WORDS + 1);
    localparam int BCW   = $clog2(SHIFT_CYCLE);

    lfsr_state_e    state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic           lfsr_clk_q, lfsr_clk_d;
    logic [1:0]     lfsr_dout_q, lfsr_dout_d;
    logic           mode_q, mode_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           buf_wr;
    logic           buf_shift;
    logic [1:0]     buf_lsb;

    lfsr_seed_load_buffer #(
        .SHIFT_CYCLE (SHIFT_CYCLE),
        .IDX_W       (WCW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (buf_wr),
        .wr_idx   (word_cnt_q),
        .wr_data  (fifo.in_fifo_dout),
        .shift_en (buf_shift),
        .lsb      (buf_lsb)
    );

    assign fifo.in_fifo_rd_en = (state_q == ST_LOAD_REQ) && !fifo.in_fifo_empty;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        lfsr_clk_d  = lfsr_clk_q;
        lfsr_dout_d = lfsr_dout_q;
        mode_d      = mode_q;
        done_d      = 1'b0;
        buf_wr      = 1'b0;
        buf_shift   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (lfsr_load_trigger) begin
                    state_d    = ST_LOAD_REQ;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_LOAD_REQ: begin
                if (!fifo.in_fifo_empty)
                    state_d = ST_LOAD_CAP;
            end
            ST_LOAD_CAP: begin
                buf_wr     = 1'b1;
                word_cnt_d = word_cnt_q + WCW'(1);
                if (word_cnt_q == WCW'(WORDS - 1))
                    state_d = ST_MODE_ON;
                else
                    state_d = ST_LOAD_REQ;
            end
            ST_MODE_ON: begin
                mode_d     = 1'b1;
                lfsr_clk_d = 1'b0;
                state_d    = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                // Data only moves while lfsr_clk is low.
                lfsr_clk_d  = 1'b0;
                lfsr_dout_d = buf_lsb;
                state_d     = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                lfsr_clk_d = 1'b1;
                buf_shift  = 1'b1;
                bit_cnt_d  = bit_cnt_q + BCW'(1);
                if (bit_cnt_q == BCW'(SHIFT_CYCLE - 1))
                    state_d = ST_MODE_OFF;
                else
                    state_d = ST_SHIFT_LO;
            end
            ST_MODE_OFF: begin
                lfsr_clk_d  = 1'b0;
                lfsr_dout_d = '0;
                mode_d      = 1'b0;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything; popped words are simply dropped.
        if (lfsr_load_abort) begin
            state_d     = ST_IDLE;
            word_cnt_d  = '0;
            bit_cnt_d   = '0;
            lfsr_clk_d  = 1'b0;
            lfsr_dout_d = '0;
            mode_d      = 1'b0;
            done_d      = 1'b0;
            buf_wr      = 1'b0;
            buf_shift   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            lfsr_clk_q  <= 1'b0;
            lfsr_dout_q <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            lfsr_clk_q  <= lfsr_clk_d;
            lfsr_dout_q <= lfsr_dout_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign lfsr_clk       = lfsr_clk_q;
    assign lfsr_dout      = lfsr_dout_q;
    assign lfsr_load_mode = mode_q;
    assign load_busy      = busy_q;
    assign load_done      = done_q;

endmodule

// File: tb/tb_lfsr_seed_load.sv
// Testbench for lfsr_seed_load: FIFO model, chip chain model,
// table of seed loads plus abort / reset / trigger-hold sequences.
module tb_lfsr_seed_load;

    localparam int SC  = 320;
    localparam int NW  = 20;
    localparam int NPC = 10;

    typedef struct {
        logic [31:0] base;
        logic [31:0] step;
        int          gap;
        int          exp_lat;
        logic [1:0]  exp_first;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig  = 1'b0;
    logic       abort = 1'b0;
    logic       lfsr_clk;
    logic [1:0] lfsr_dout;
    logic       lfsr_load_mode;
    logic       load_busy;
    logic       load_done;

    lfsr_seed_load_if fifo ();

    lfsr_seed_load #(.SHIFT_CYCLE(SC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lfsr_load_trigger (trig),
        .lfsr_load_abort   (abort),
        .fifo              (fifo),
        .lfsr_clk          (lfsr_clk),
        .lfsr_dout         (lfsr_dout),
        .lfsr_load_mode    (lfsr_load_mode),
        .load_busy         (load_busy),
        .load_done         (load_done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo.in_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo.in_fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo.in_fifo_dout <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int rd_total = 0;
    int viol_total = 0;
    int done_total = 0;
    int edge_total = 0;
    int rd_at_mode = 0;
    int edges_at_mode = 0;
    logic mode_prev = 1'b0;
    logic [1:0] first_bits = 2'b00;
    logic [SC-1:0] ch0 = '0;
    logic [SC-1:0] ch1 = '0;

    always @(posedge clk) begin
        if (fifo.in_fifo_rd_en) rd_total++;
        if (fifo.in_fifo_rd_en && fifo.in_fifo_empty) viol_total++;
        if (load_done) done_total++;
        if (lfsr_load_mode && !mode_prev) begin
            rd_at_mode = rd_total;
            edges_at_mode = edge_total;
        end
        mode_prev = lfsr_load_mode;
    end

    always @(posedge lfsr_clk) begin
        if (lfsr_load_mode) begin
            if (edge_total == edges_at_mode) first_bits = lfsr_dout;
            ch0 = {lfsr_dout[0], ch0[SC-1:1]};
            ch1 = {lfsr_dout[1], ch1[SC-1:1]};
            edge_total++;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic chk_words(input string tag, input logic [31:0] base,
                             input logic [31:0] step, input int off);
        logic [31:0] exp_w;
        logic [31:0] got_w;
        for (int k = 0; k < NW; k++) begin
            exp_w = base + 32'(off + k) * step;
            if (k < NPC) got_w = ch0[k*32 +: 32];
            else         got_w = ch1[(k-NPC)*32 +: 32];
            chk($sformatf("%s.word%0d", tag, k), 64'(got_w), 64'(exp_w));
        end
    endtask

    // Counts negedges until load_done is seen; lat enters as cycles so far.
    task automatic wait_done(inout int lat, input int limit);
        while (!load_done && lat < limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s_rd, s_edge, s_viol, s_done, lat, pushed;
        pushed = 0;
        if (v.gap == 0) begin
            for (int k = 0; k < NW; k++) begin
                push_word(v.base + 32'(k) * v.step);
                pushed++;
            end
        end
        @(negedge clk);
        s_rd = rd_total; s_edge = edge_total;
        s_viol = viol_total; s_done = done_total;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        lat = 1;
        while (!load_done && lat < 3000) begin
            if (v.gap > 0 && pushed < NW && (lat % v.gap) == 0) begin
                push_word(v.base + 32'(pushed) * v.step);
                pushed++;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, ".done_seen"}, 64'(load_done), 64'd1);
        if (v.exp_lat > 0) chk({tag, ".latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, ".rd_pulses"}, 64'(rd_total - s_rd), 64'(NW));
        chk({tag, ".rd_while_empty"}, 64'(viol_total - s_viol), 64'd0);
        chk({tag, ".rd_before_mode"}, 64'(rd_at_mode - s_rd), 64'(NW));
        chk({tag, ".edges_before_mode"}, 64'(edges_at_mode - s_edge), 64'd0);
        chk({tag, ".rising_edges"}, 64'(edge_total - s_edge), 64'(SC));
        chk({tag, ".first_bits"}, 64'(first_bits), 64'(v.exp_first));
        chk_words(tag, v.base, v.step, 0);
        @(negedge clk);
        chk({tag, ".done_width"}, 64'(load_done), 64'd0);
        chk({tag, ".done_count"}, 64'(done_total - s_done), 64'd1);
        chk({tag, ".idle_outputs"},
            64'({load_busy, lfsr_load_mode, lfsr_clk, lfsr_dout}), 64'd0);
    endtask

    vec_t vecs [5];

    initial begin
        int s_rd, s_edge, s_done, lat, lim;

        vecs[0] = '{32'h0000_0001, 32'h0000_0001, 0, 684, 2'b11};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 0, 684, 2'b11};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 0, 684, 2'b00};
        vecs[3] = '{32'hA5A5_A5A4, 32'h0000_0002, 0, 684, 2'b00};
        vecs[4] = '{32'h1234_5679, 32'h0101_0101, 7, -1,  2'b11};

        #12;
        chk("reset.outputs",
            64'({load_busy, load_done, lfsr_load_mode, lfsr_clk, lfsr_dout,
                 fifo.in_fifo_rd_en}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle.no_rd_en", 64'(fifo.in_fifo_rd_en), 64'd0);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort after 100 rising edges.
        for (int k = 0; k < NW; k++) push_word(32'hDEAD_0000 + 32'(k));
        @(negedge clk);
        s_edge = edge_total; s_done = done_total;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        lim = 0;
        while (edge_total - s_edge < 100 && lim < 3000) begin
            @(negedge clk);
            lim++;
        end
        chk("abort.reached_bit100", 64'(edge_total - s_edge), 64'd100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.outputs",
            64'({load_busy, lfsr_load_mode, lfsr_clk}), 64'd0);
        repeat (10) @(negedge clk);
        chk("abort.no_done", 64'(done_total - s_done), 64'd0);
        chk("abort.no_more_edges", 64'(edge_total - s_edge), 64'd100);
        run_vec('{32'hCAFE_0000, 32'h0001_0003, 0, 684, 2'b00}, "post_abort");

        // Asynchronous reset while lfsr_clk is high.
        for (int k = 0; k < NW; k++) push_word(32'h5A5A_0000 ^ 32'(k));
        @(negedge clk);
        s_edge = edge_total;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        lim = 0;
        while (edge_total - s_edge < 50 && lim < 3000) begin
            @(negedge clk);
            lim++;
        end
        chk("rst.clk_high_before", 64'(lfsr_clk), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async_outputs",
            64'({load_busy, load_done, lfsr_load_mode, lfsr_clk, lfsr_dout,
                 fifo.in_fifo_rd_en}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec('{32'h0F0F_0F0F, 32'h1111_1110, 0, 684, 2'b11}, "post_rst");

        // Trigger held for 3 cycles: one load only.
        for (int k = 0; k < NW; k++) push_word(32'h7700_0000 + 32'(3 * k));
        @(negedge clk);
        s_rd = rd_total; s_done = done_total;
        trig = 1'b1;
        repeat (3) @(negedge clk);
        trig = 1'b0;
        lat = 3;
        wait_done(lat, 3000);
        chk("hold3.latency", 64'(lat), 64'd684);
        repeat (20) @(negedge clk);
        chk("hold3.single_load_busy", 64'(load_busy), 64'd0);
        chk("hold3.rd_pulses", 64'(rd_total - s_rd), 64'(NW));
        chk("hold3.done_count", 64'(done_total - s_done), 64'd1);
        chk_words("hold3", 32'h7700_0000, 32'd3, 0);

        // Trigger held through DONE: a second load follows.
        for (int k = 0; k < 2 * NW; k++) push_word(32'h0000_1000 + 32'(7 * k));
        @(negedge clk);
        s_rd = rd_total; s_edge = edge_total; s_done = done_total;
        trig = 1'b1;
        @(negedge clk);
        lat = 1;
        wait_done(lat, 3000);
        chk("hold_done.first_latency", 64'(lat), 64'd684);
        @(negedge clk);
        trig = 1'b0;
        chk("hold_done.restart_busy", 64'(load_busy), 64'd1);
        lat = 1;
        wait_done(lat, 3000);
        chk("hold_done.second_latency", 64'(lat), 64'd684);
        chk("hold_done.rd_pulses", 64'(rd_total - s_rd), 64'(2 * NW));
        chk("hold_done.edges", 64'(edge_total - s_edge), 64'(2 * SC));
        @(negedge clk);
        chk("hold_done.done_count", 64'(done_total - s_done), 64'd2);
        chk_words("hold_done", 32'h0000_1000, 32'd7, NW);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
